// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that sequences NREQ byte sources onto one UART transmitter.
// Optional macro UART_TX_ARB_TIMEOUT_EN adds the WAIT_BUSY timeout and the sticky err_timeout_o flag.
`timescale 1ns/1ps
module uart_tx_arb #(
  parameter int NREQ    = 4,
  parameter int BUSY_TO = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*8-1:0] req_data_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [7:0]        tx_din_o,
  output logic              tx_first_o,
  input  logic              tx_done_i,
  output logic              busy_o,
  output logic              err_timeout_o,
  input  logic              err_clr_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK} state_t;

  state_t          state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   win_q;
  logic [PW-1:0]   win_d;
  logic [7:0]      din_d;
  logic [7:0]      tx_din_q;
  logic [NREQ-1:0] ack_q;
  logic            tx_first_q;
  logic            busy_q;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
  endfunction

  // Scan downward so the lowest offset from rr_ptr_q is the last (winning) assignment.
  always_comb begin
    win_d = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[(int'(rr_ptr_q) + i) % NREQ]) win_d = PW'((int'(rr_ptr_q) + i) % NREQ);
    end
  end

  assign din_d = req_data_i[int'(win_d)*8 +: 8];

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [7:0] to_cnt_q;
  logic       err_q;
  assign err_timeout_o = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_timeout_o  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      win_q      <= '0;
      tx_din_q   <= '0;
      ack_q      <= '0;
      tx_first_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      ack_q      <= '0;
      tx_first_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      // A timeout set later in this block overrides the clear.
      if (err_clr_i) err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (|req_i && tx_done_i) begin
            win_q    <= win_d;
            tx_din_q <= din_d;
            busy_q   <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          tx_first_q <= 1'b1;
          state_q    <= WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
          to_cnt_q   <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (!tx_done_i) state_q <= WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (to_cnt_q == 8'(BUSY_TO - 1)) begin
            err_q    <= 1'b1;
            ack_q    <= NREQ'(1) << win_q;
            rr_ptr_q <= wrap_inc(win_q);
            state_q  <= ACK;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
`endif
        end
        WAIT_DONE: begin
          if (tx_done_i) begin
            ack_q    <= NREQ'(1) << win_q;
            rr_ptr_q <= wrap_inc(win_q);
            state_q  <= ACK;
          end
        end
        ACK: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign tx_din_o   = tx_din_q;
  assign tx_first_o = tx_first_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: transaction-level timeline model plus directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_uart_tx_arb;
  localparam int NREQ    = 4;
  localparam int BUSY_TO = 15;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [7:0] RR_EXP [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0]   ack_o;
  logic [7:0]        tx_din;
  logic              tx_first;
  logic              tx_done = 1'b1;
  logic              busy;
  logic              err_timeout;
  logic              err_clr = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arb #(.NREQ(NREQ), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_data_i(req_data), .ack_o(ack_o),
    .tx_din_o(tx_din), .tx_first_o(tx_first), .tx_done_i(tx_done), .busy_o(busy),
    .err_timeout_o(err_timeout), .err_clr_i(err_clr)
  );

  int checks = 0, errors = 0, cyc = 0;

  // Model: one transaction at a time, described by its grant edge and ack edge.
  bit              m_active, m_low, m_err;
  int              m_g, m_ack, m_free, m_w, m_ptr;
  logic [7:0]      m_din;
  logic [NREQ-1:0] exp_ack;

  // Transmitter stub and stimulus controls.
  int tx_drop = 0, tx_low = 0;
  bit rand_on = 0, glitch = 0, force_nr = 0, never = 0, fixed = 0;

  int         nf, na, nb, ng, f, seen;
  logic [7:0] got [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int scan(input int p, input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return 0;
  endfunction

  // Advance the model by the edge that just occurred, using the inputs it sampled.
  task automatic model_edge();
    bit set;
    if (!rst_n) begin
      m_active = 0; m_low = 0; m_err = 0; m_ptr = 0; m_w = 0; m_din = '0;
      m_g = 0; m_ack = -1; m_free = 0;
      return;
    end
    set = 0;
    if (m_active && m_ack >= 0 && cyc == m_ack + 1) m_active = 0;
    if (m_active && m_ack < 0 && cyc >= m_g + 2) begin
      if (!m_low) begin
        if (!tx_done) m_low = 1;
        else if (TO_EN && cyc - (m_g + 1) == BUSY_TO) begin set = 1; m_ack = cyc; end
      end else if (tx_done) m_ack = cyc;
      if (m_ack == cyc) begin
        m_ptr  = (m_w + 1) % NREQ;
        m_free = cyc + 2;
      end
    end else if (!m_active && cyc >= m_free && req != '0 && tx_done) begin
      m_w = scan(m_ptr, req);
      m_din = req_data[8*m_w +: 8];
      m_active = 1; m_g = cyc; m_low = 0; m_ack = -1;
    end
    if (TO_EN) m_err = set ? 1'b1 : (err_clr ? 1'b0 : m_err);
  endtask

  task automatic compare();
    exp_ack = (m_active && cyc == m_ack) ? (NREQ'(1) << m_w) : '0;
    chk("busy", 32'(busy), 32'(m_active));
    chk("tx_first", 32'(tx_first), 32'(m_active && cyc == m_g + 1));
    chk("ack", 32'(ack_o), 32'(exp_ack));
    chk("tx_din", 32'(tx_din), 32'(m_din));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
  endtask

  task automatic drive();
    if (!rst_n) begin
      tx_drop = 0; tx_low = 0;
    end else if (tx_first) begin
      if (fixed) begin tx_drop = 0; tx_low = 10; end
      else if (never) begin tx_drop = 1000; tx_low = 1; end
      else begin
        tx_drop = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 3));
        tx_low  = int'($urandom_range(2, 12));
      end
    end
    if (force_nr) tx_done = 1'b0;
    else if (tx_low > 0) begin
      if (tx_drop > 0) begin tx_drop--; tx_done = 1'b1; end
      else begin tx_low--; tx_done = 1'b0; end
    end else tx_done = glitch ? ($urandom_range(0, 7) != 0) : 1'b1;
    if (rand_on) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && exp_ack[i]) begin
          if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
          else req_data[8*i +: 8] = 8'($urandom);
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
      err_clr = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    model_edge();
    compare();
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rand_on = 0; glitch = 0; force_nr = 0; never = 0; fixed = 0;
    req = '0; req_data = '0; err_clr = 1'b0; tx_done = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded %0d ns", 1_000_000);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    step();
    chk("reset_outputs", 32'({ack_o, tx_din, tx_first, busy, err_timeout}), 32'd0);

    // Single request from requester 1.
    do_reset();
    req = 4'b0010; req_data = 32'h0000_A500; nf = 0; na = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (tx_first) begin nf++; chk("single_din", 32'(tx_din), 32'h0000_00A5); end
      if (ack_o != '0) begin na++; chk("single_ack", 32'(ack_o), 32'b0010); req = '0; end
    end
    chk("single_first_count", 32'(nf), 32'd1);
    chk("single_ack_count", 32'(na), 32'd1);
    chk("single_busy_after", 32'(busy), 32'd0);

    // Round robin with all requesters permanently pending.
    do_reset();
    req = 4'hF; req_data = 32'h1312_1110; ng = 0;
    for (int k = 0; k < 400 && ng < 5; k++) begin
      step();
      if (tx_first) begin got[ng] = tx_din; ng++; end
      if (ack_o != '0) chk("rr_ack_onehot", 32'($countones(ack_o)), 32'd1);
    end
    chk("rr_grant_count", 32'(ng), 32'd5);
    for (int i = 0; i < ng; i++) chk("rr_grant_byte", 32'(got[i]), 32'(RR_EXP[i]));
    req = '0;

    // Transmitter not ready while requester 2 waits.
    do_reset();
    force_nr = 1; tx_done = 1'b0; req = 4'b0100; req_data = 32'h003C_0000; nf = 0; nb = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tx_first) nf++;
      if (busy) nb++;
    end
    chk("nr_first_count", 32'(nf), 32'd0);
    chk("nr_busy_count", 32'(nb), 32'd0);
    force_nr = 0; tx_done = 1'b1;
    step();
    chk("nr_busy_after_release", 32'(busy), 32'd1);
    chk("nr_din_after_release", 32'(tx_din), 32'h0000_003C);
    seen = 0;
    for (int k = 0; k < 60 && seen == 0; k++) begin
      step();
      if (ack_o != '0) begin seen = 1; chk("nr_ack", 32'(ack_o), 32'b0100); req = '0; end
    end
    chk("nr_ack_seen", 32'(seen), 32'd1);

    // Transmitter never leaves idle after the start pulse.
    do_reset();
    never = 1; req = 4'b1000; req_data = 32'h7E00_0000; f = 0; seen = 0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int k = 0; k < 60 && seen == 0; k++) begin
      step();
      if (tx_first) f = cyc;
      if (err_timeout) begin
        seen = 1;
        chk("to_latency", 32'(cyc - f), 32'd15);
        chk("to_ack", 32'(ack_o), 32'b1000);
        req = '0;
      end
    end
    chk("to_seen", 32'(seen), 32'd1);
    step();
    step();
    chk("to_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_cleared", 32'(err_timeout), 32'd0);
`else
    na = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      err_clr = (k % 7 == 0);
      if (ack_o != '0) na++;
      if (err_timeout) seen++;
    end
    err_clr = 1'b0;
    chk("noto_err_count", 32'(seen), 32'd0);
    chk("noto_ack_count", 32'(na), 32'd0);
    chk("noto_still_busy", 32'(busy), 32'd1);
`endif

    // Reset asserted while the frame is in flight.
    do_reset();
    fixed = 1; req = 4'b0010; req_data = 32'h0000_5A00; seen = 0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      step();
      if (tx_first) seen = 1;
    end
    chk("rst_first_seen", 32'(seen), 32'd1);
    for (int k = 0; k < 4; k++) step();
    chk("rst_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outputs", 32'({ack_o, tx_din, tx_first, busy, err_timeout}), 32'd0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 60 && seen == 0; k++) begin
      step();
      if (ack_o != '0) begin
        seen = 1;
        chk("rst_regrant_ack", 32'(ack_o), 32'b0010);
        chk("rst_regrant_din", 32'(tx_din), 32'h0000_005A);
        req = '0;
      end
    end
    chk("rst_regrant_seen", 32'(seen), 32'd1);

    // Random traffic against the model.
    do_reset();
    rand_on = 1; glitch = 1;
    for (int k = 0; k < 3000; k++) step();
    rand_on = 0; glitch = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
